door_ctrl_timed: RTL and testbench
==================================

# door_ctrl_timed

Parametrised automatic-door controller, successor to the four-bit door state machine: one clocked Moore FSM that drives open/close motor enables from a presence sensor, an emergency stop and two limit switches. It adds input synchronisation, presence debounce, a programmable hold-open time, reopen-on-presence while closing, a motor-run timeout with a latched fault, and inconsistent-limit detection. It sits directly behind the top-level pin wrapper, which maps its ports onto the user I/O bytes.

## Interface
- HOLD_CYCLES, 8: cycles the door stays in OPEN after presence clears; must be ≥1.
- MOTOR_TIMEOUT, 32: maximum cycles in OPENING or CLOSING before FAULT; must be ≥2.
- DEB_CYCLES, 2: consecutive synchronised-high samples of sen required before presence is accepted; must be ≥1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sen  in  1  presence sensor, asynchronous.
- se  in  1  emergency stop, level, asynchronous.
- la  in  1  open limit switch, asynchronous.
- lc  in  1  closed limit switch, asynchronous.
- ma  out  1  open-motor enable.
- mc  out  1  close-motor enable.
- state  out  3  current state code.
- fault  out  1  latched fault flag.

## Operation
- All four inputs pass through a 2-flop synchroniser (reset value 0). la, lc and se are used synchronised but not debounced.
- Presence filter: a saturating counter increments on each edge where synchronised sen=1 and clears when it is 0. sen_d is a registered flag, set when the count reaches DEB_CYCLES and cleared on the first synchronised-low sample.
- States and codes: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, STOP=4, FAULT=5. Codes 6 and 7 go to FAULT on the next edge.
- Transition priority within a state: se, then la&lc both high, then limit reached, then timeout, then sen_d.
- CLOSED: se→STOP; sen_d→OPENING.
- OPENING: se→STOP; la&lc→FAULT; la→OPEN; motor timer expiry→FAULT.
- OPEN: se→STOP; hold counter==0 and !sen_d→CLOSING; sen_d reloads the hold counter.
- CLOSING: se→STOP; la&lc→FAULT; lc→CLOSED; sen_d→OPENING (reopen); motor timer expiry→FAULT.
- STOP: remains while se=1. On se=0: la→OPEN (hold counter loaded), else lc→CLOSED, else OPENING.
- FAULT: absorbing; only rst leaves it.
- Outputs are decoded from the state register only (Moore):
  - ma=1 iff OPENING.
  - mc=1 iff CLOSING.
  - fault=1 iff FAULT.
  - ma and mc are never both 1.
- Hold counter, width $clog2(HOLD_CYCLES+1):
  - Loaded with HOLD_CYCLES-1 on every entry to OPEN and on every OPEN cycle with sen_d=1.
  - Otherwise decrements in OPEN, saturating at 0.
- Motor timer, width $clog2(MOTOR_TIMEOUT):
  - Cleared on every entry to OPENING or CLOSING, including a reopen from CLOSING.
  - Increments each cycle in those states.
  - Expiry means the timer equals MOTOR_TIMEOUT-1 and the relevant limit is low on that edge.
- Reset: state=CLOSED, all counters and synchroniser flops 0, sen_d=0, so ma=mc=fault=0 and state=0. rst asserted in any state, including FAULT or mid-motion, takes effect on the next edge.

## Timing
- Input to synchronised value: 2 edges.
- sen high before edge 0 and held: sen_d high after edge 1+DEB_CYCLES; state=OPENING and ma=1 after edge 2+DEB_CYCLES (edge 4 at default).
- se high before edge 0: state=STOP and motors off after edge 3. se low before edge n: STOP exits after edge n+3.
- la high before edge 0 while OPENING: OPEN after edge 3, so ma drops after edge 3.
- With sen_d low throughout, OPEN lasts exactly HOLD_CYCLES cycles and CLOSING is entered at the following edge.
- Without the relevant limit, OPENING/CLOSING lasts exactly MOTOR_TIMEOUT cycles, then FAULT.
- A sen pulse shorter than DEB_CYCLES synchronised samples is ignored.

## Test plan
- Nominal cycle (defaults): sen high 4 cycles from reset, then low. Required: ma=1 after edge 4. Assert la: state=2, ma=0. 8 cycles later state=3, mc=1. Assert lc: state=0, mc=0.
- Glitch rejection: 1-cycle sen pulse in CLOSED → state stays 0, ma stays 0. 3-cycle pulse → state becomes OPENING (state=1).
- Reopen: sen rises mid-CLOSING → state 3→1 and ma=1 with a fresh timeout. Then withhold la for 32 cycles → state=5, fault=1, ma=mc=0.
- Emergency stop: se in OPENING → state=4, ma=mc=0. Release se with la=0, lc=0 → OPENING. Release with la=1 → OPEN.
- Inconsistent limits: la=lc=1 during CLOSING → FAULT. sen and se are then ignored until rst, after which state=0, fault=0.
- Parameter sweep (HOLD_CYCLES=1, MOTOR_TIMEOUT=2, DEB_CYCLES=1): OPEN lasts 1 cycle; FAULT after 2 motor cycles; ma=1 three edges after sen rises.

Source files
------------

// File: rtl/door_ctrl_timed.sv
// door_ctrl_timed: automatic-door Moore FSM with synchronised inputs, presence debounce,
// hold-open timer, reopen-on-presence, motor-run timeout and latched fault.
module door_ctrl_timed #(
    parameter int HOLD_CYCLES   = 8,
    parameter int MOTOR_TIMEOUT = 32,
    parameter int DEB_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sen,
    input  logic       se,
    input  logic       la,
    input  logic       lc,
    output logic       ma,
    output logic       mc,
    output logic [2:0] state,
    output logic       fault
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int MW = $clog2(MOTOR_TIMEOUT);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
    localparam logic [MW-1:0] MT_LAST = MW'(MOTOR_TIMEOUT - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_M1  = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        STOP    = 3'd4,
        FAULT   = 3'd5
    } st_t;

    st_t st, nxt;
    logic [3:0] s1, s2;
    logic se_r, la_r, lc_r, sen_d;
    logic [DW-1:0] deb;
    logic [HW-1:0] hold;
    logic [MW-1:0] tmr;

    // se/la/lc get one extra register so they line up with the registered sen_d
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            se_r  <= 1'b0;
            la_r  <= 1'b0;
            lc_r  <= 1'b0;
            deb   <= '0;
            sen_d <= 1'b0;
            hold  <= '0;
            tmr   <= '0;
            st    <= CLOSED;
        end else begin
            s1    <= {sen, se, la, lc};
            s2    <= s1;
            {se_r, la_r, lc_r} <= s2[2:0];
            deb   <= s2[3] ? ((deb == DEB_MAX) ? deb : deb + 1'b1) : '0;
            sen_d <= s2[3] && (deb >= DEB_M1);
            hold  <= (nxt == OPEN && (st != OPEN || sen_d)) ? HOLD_LD :
                     (st == OPEN && hold != '0) ? hold - 1'b1 : hold;
            tmr   <= (nxt != st || !(st == OPENING || st == CLOSING)) ? '0 : tmr + 1'b1;
            st    <= nxt;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            CLOSED:  nxt = se_r ? STOP : sen_d ? OPENING : CLOSED;
            OPENING: nxt = se_r ? STOP : (la_r && lc_r) ? FAULT : la_r ? OPEN :
                           (tmr == MT_LAST) ? FAULT : OPENING;
            OPEN:    nxt = se_r ? STOP : (hold == '0 && !sen_d) ? CLOSING : OPEN;
            CLOSING: nxt = se_r ? STOP : (la_r && lc_r) ? FAULT : lc_r ? CLOSED :
                           (tmr == MT_LAST) ? FAULT : sen_d ? OPENING : CLOSING;
            STOP:    nxt = se_r ? STOP : la_r ? OPEN : lc_r ? CLOSED : OPENING;
            default: nxt = FAULT;
        endcase
    end

    assign ma    = (st == OPENING);
    assign mc    = (st == CLOSING);
    assign fault = (st == FAULT);
    assign state = st;
endmodule

// File: tb/tb_door_ctrl_timed.sv
// tb_door_ctrl_timed: directed plus randomized checks of two door_ctrl_timed instances
// (default and minimum parameters) against a timestamp-based reference model.
module tb_door_ctrl_timed;
    logic clk = 1'b0, rst = 1'b1, sen = 1'b0, se = 1'b0, la = 1'b0, lc = 1'b0;
    logic ma0, mc0, f0, ma1, mc1, f1;
    logic [2:0] st0, st1;
    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    door_ctrl_timed #(.HOLD_CYCLES(8), .MOTOR_TIMEOUT(32), .DEB_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .sen(sen), .se(se), .la(la), .lc(lc),
        .ma(ma0), .mc(mc0), .state(st0), .fault(f0));
    door_ctrl_timed #(.HOLD_CYCLES(1), .MOTOR_TIMEOUT(2), .DEB_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .sen(sen), .se(se), .la(la), .lc(lc),
        .ma(ma1), .mc(mc1), .state(st1), .fault(f1));

    // History bit k holds the input sampled k+1 edges before the current one;
    // timing is kept as edge timestamps (entry, last hold refresh).
    typedef struct {
        int st;
        int ec;
        int ent;
        int rf;
        logic [15:0] hse, hla, hlc, hsen;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t step(mdl_t m, logic r, logic i_sen, logic i_se, logic i_la,
                                  logic i_lc, int h, int t, int d);
        mdl_t n = m;
        int nx;
        logic s, a, c, p;
        if (r) begin
            n.st = 0; n.ec = 0; n.ent = 0; n.rf = 0;
            n.hse = '0; n.hla = '0; n.hlc = '0; n.hsen = '0;
            return n;
        end
        s = m.hse[2];
        a = m.hla[2];
        c = m.hlc[2];
        p = 1'b1;
        for (int k = 2; k < d + 2; k++) p &= m.hsen[k];
        case (m.st)
            0: nx = s ? 4 : p ? 1 : 0;
            1: nx = s ? 4 : (a && c) ? 5 : a ? 2 : (m.ec - m.ent == t) ? 5 : 1;
            2: nx = s ? 4 : (m.ec - m.rf >= h && !p) ? 3 : 2;
            3: nx = s ? 4 : (a && c) ? 5 : c ? 0 : (m.ec - m.ent == t) ? 5 : p ? 1 : 3;
            4: nx = s ? 4 : a ? 2 : c ? 0 : 1;
            default: nx = 5;
        endcase
        if (nx != m.st) begin
            n.ent = m.ec;
            if (nx == 2) n.rf = m.ec;
        end else if (nx == 2 && p) begin
            n.rf = m.ec;
        end
        n.st = nx;
        n.ec = m.ec + 1;
        n.hse = {m.hse[14:0], i_se};
        n.hla = {m.hla[14:0], i_la};
        n.hlc = {m.hlc[14:0], i_lc};
        n.hsen = {m.hsen[14:0], i_sen};
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = step(m0, rst, sen, se, la, lc, 8, 32, 2);
        m1 = step(m1, rst, sen, se, la, lc, 1, 2, 1);
    end

    task automatic cmp(input string nm, input logic [2:0] s, input logic a, input logic c,
                       input logic f, input mdl_t m);
        logic [2:0] es;
        es = m.st[2:0];
        total++;
        if ({s, a, c, f} !== {es, es == 3'd1, es == 3'd3, es == 3'd5}) begin
            bad++;
            $display("FAIL %s t=%0t got st=%0d ma=%b mc=%b fault=%b want st=%0d ma=%b mc=%b fault=%b",
                     nm, $time, s, a, c, f, es, es == 3'd1, es == 3'd3, es == 3'd5);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (chk_en) begin
                cmp("model_u0", st0, ma0, mc0, f0, m0);
                cmp("model_u1", st1, ma1, mc1, f1, m1);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic wait_st(input logic [2:0] want, input int lim);
        int n = 0;
        while (st0 !== want && n < lim) begin
            tick(1);
            n++;
        end
        chk("wait_state", {5'd0, st0}, {5'd0, want});
    endtask

    initial begin
        tick(2);
        chk_en = 1'b1;
        chk("reset_state", {5'd0, st0}, 8'd0);
        chk("reset_outs", {5'd0, ma0, mc0, f0}, 8'd0);
        // nominal cycle
        rst = 1'b0; sen = 1'b1;
        tick(4);
        chk("nom_closed_e3", {5'd0, st0}, 8'd0);
        chk("min_ma_e3", {7'd0, ma1}, 8'd1);
        tick(1);
        chk("nom_opening_e4", {5'd0, st0}, 8'd1);
        chk("nom_ma_e4", {7'd0, ma0}, 8'd1);
        sen = 1'b0; la = 1'b1;
        tick(4);
        chk("nom_open", {5'd0, st0}, 8'd2);
        chk("nom_ma_off", {7'd0, ma0}, 8'd0);
        chk("min_motor_fault", {5'd0, st1}, 8'd5);
        la = 1'b0;
        tick(7);
        chk("nom_hold", {5'd0, st0}, 8'd2);
        tick(1);
        chk("nom_closing", {5'd0, st0}, 8'd3);
        chk("nom_mc", {7'd0, mc0}, 8'd1);
        lc = 1'b1;
        tick(4);
        chk("nom_closed", {5'd0, st0, mc0}, 8'd0);
        lc = 1'b0;
        // glitch rejection
        sen = 1'b1; tick(1); sen = 1'b0;
        tick(6);
        chk("glitch_state", {5'd0, st0}, 8'd0);
        chk("glitch_ma", {7'd0, ma0}, 8'd0);
        sen = 1'b1; tick(3); sen = 1'b0;
        tick(2);
        chk("pulse3_opening", {5'd0, st0}, 8'd1);
        // reopen, then motor timeout
        la = 1'b1; tick(4); la = 1'b0;
        chk("reopen_open", {5'd0, st0}, 8'd2);
        wait_st(3'd3, 20);
        sen = 1'b1;
        tick(5);
        sen = 1'b0;
        chk("reopen_state", {5'd0, st0}, 8'd1);
        chk("reopen_ma", {7'd0, ma0}, 8'd1);
        tick(31);
        chk("timeout_not_yet", {5'd0, st0}, 8'd1);
        tick(1);
        chk("timeout_fault", {5'd0, st0}, 8'd5);
        chk("timeout_outs", {5'd0, ma0, mc0, f0}, 8'd1);
        // emergency stop
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("rst_from_fault", {4'd0, st0, f0}, 8'd0);
        sen = 1'b1;
        wait_st(3'd1, 10);
        sen = 1'b0; se = 1'b1;
        tick(4);
        chk("stop_state", {5'd0, st0}, 8'd4);
        chk("stop_motors", {6'd0, ma0, mc0}, 8'd0);
        se = 1'b0;
        tick(4);
        chk("stop_to_opening", {5'd0, st0}, 8'd1);
        se = 1'b1; tick(4);
        la = 1'b1; tick(1);
        se = 1'b0;
        tick(4);
        chk("stop_to_open", {5'd0, st0}, 8'd2);
        la = 1'b0;
        // inconsistent limits while closing
        wait_st(3'd3, 20);
        la = 1'b1; lc = 1'b1;
        tick(4);
        chk("limits_fault", {4'd0, st0, f0}, 8'd11);
        la = 1'b0; lc = 1'b0; sen = 1'b1; se = 1'b1;
        tick(8);
        chk("fault_absorbing", {5'd0, st0}, 8'd5);
        sen = 1'b0; se = 1'b0;
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("fault_cleared", {4'd0, st0, f0}, 8'd0);
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 150) == 0;
            if (($urandom % 5) == 0) sen = ~sen;
            if (($urandom % 30) == 0) se = ~se;
            la = ($urandom % 5) == 0;
            lc = ($urandom % 5) == 0;
            tick(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
